instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch unit that feeds the instruction register stage. It holds the program counter and runs a request/ready handshake with instruction memory. Each returned 16-bit word is latched and presented with a one-cycle `irw` write-enable pulse for the instruction register to capture. It also accepts PC redirects from branch/jump logic and a stall from downstream control.

## Interface
Parameters:
- `RESET_PC`, 16'h0000, PC value loaded on reset.

Ports:
- Clocking: one clock; reset is asynchronous and active-low.
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: async active-low reset.
- `fetch_en` input 1: fetching permitted.
- `stall` input 1: blocks starting a new memory request.
- `redirect` input 1: load `redirect_pc` into the PC; highest priority.
- `redirect_pc` input 16: target address.
- `mem_req` output 1: memory read request.
- `mem_addr` output 16: read address, equal to `pc`.
- `mem_rdata` input 16: memory read data, valid when `mem_ready`=1.
- `mem_ready` input 1: memory completes the request this cycle.
- `instr` output 16: last fetched instruction word; drives the instruction register `instr` input.
- `irw` output 1: one-cycle write pulse to the instruction register.
- `pc` output 16: address of the next instruction to fetch.
- `instr_pc` output 16: address the current `instr` was fetched from.
- `busy` output 1: high in REQ or DELIV.

## Operation
- Word-addressed: one 16-bit instruction per address; PC increments by 1, modulo 2^16 (16'hFFFF+1 = 16'h0000).
- FSM states: IDLE, REQ, DELIV. All outputs are registered or decoded from state only; there are no combinational paths from inputs to outputs.
- IDLE:
  - `mem_req`=0.
  - `fetch_en`=1 and `stall`=0 → REQ.
- REQ:
  - `mem_req`=1 and `mem_addr`=`pc`, held stable until `mem_ready`=1.
  - On `mem_ready`=1: `instr`←`mem_rdata`, `instr_pc`←`pc`, `pc`←`pc`+1, → DELIV.
- DELIV:
  - `irw`=1 for exactly this cycle; `mem_req`=0.
  - `fetch_en`=1 and `stall`=0 → REQ; otherwise → IDLE.
- Redirect (any state):
  - `pc`←`redirect_pc`.
  - In REQ the request is abandoned: a simultaneous `mem_ready`/`mem_rdata` is discarded, `instr`/`instr_pc` are unchanged, and no `irw` follows.
  - Next state is IDLE.
  - In DELIV, the current `irw` pulse still completes, since that instruction is already delivered.
- `stall` never aborts an outstanding request. A transaction in REQ completes and delivers; stall only gates IDLE→REQ and DELIV→REQ.
- `fetch_en` dropping in REQ does not abort the request; the FSM finishes and then goes to IDLE.
- `instr`, `instr_pc` hold their value between deliveries.
- Reset (async, any time, including mid-request):
  - state=IDLE, `pc`=`RESET_PC`, `mem_addr`=`RESET_PC`.
  - `mem_req`=0, `irw`=0, `busy`=0, `instr`=16'h0000, `instr_pc`=16'h0000.
  - An in-flight memory response after reset release is ignored because `mem_req` is low.

## Timing
- Edge n, IDLE with `fetch_en`=1, `stall`=0: `mem_req`=1 from after edge n.
- `mem_ready`=1 sampled at edge m: after edge m, `irw`=1, `instr` valid, `pc` advanced. The instruction register captures on edge m+1.
- Zero-wait memory with continuous `fetch_en`: request cycle, deliver cycle, request cycle, and so on. Throughput is one instruction per 2 cycles, and `mem_req` toggles every cycle.
- Wait states: `mem_req` and `mem_addr` stay constant for every cycle `mem_ready`=0; there is no timeout.
- Redirect at edge n: `pc`=`redirect_pc` after edge n. The first request to the new address is issued at edge n+1 at earliest.
- `redirect` and `mem_ready` both high at the same edge in REQ: redirect wins.

## Test plan
- Reset, `fetch_en`=1, zero-wait memory returning `mem_rdata`=addr^16'hA5A5 → `irw` pulses every 2nd cycle; `instr` = 16'hA5A5, 16'hA5A4, 16'hA5A7…; `instr_pc` = 0, 1, 2; `pc` after 3 fetches = 3.
- `mem_ready` delayed 3 cycles at `pc`=16'h0010 → `mem_req` high 4 cycles with `mem_addr`=16'h0010 constant; exactly one `irw`, with `instr_pc`=16'h0010.
- `redirect`=1, `redirect_pc`=16'h0200, asserted in REQ together with `mem_ready`=1 → no `irw`, `instr` unchanged. The next request uses `mem_addr`=16'h0200, and the following delivery has `instr_pc`=16'h0200.
- `stall`=1 asserted during REQ for 5 cycles, `mem_ready` after 1 cycle → that instruction delivers. No new `mem_req` while `stall`=1; fetching resumes the cycle after `stall` falls.
- `RESET_PC`=16'hFFFE, 3 fetches → `instr_pc` = FFFE, FFFF, 0000; `pc`=0001 (wrap).
- `rst_n` low mid-REQ at `pc`=16'h0042 → `mem_req`, `irw`, `busy` low immediately (asynchronously); `pc`=`RESET_PC`, `instr`=0; no stale `irw` after release.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch unit: holds the PC, runs a req/ready handshake with
// instruction memory and hands each returned word to the IR with a one-cycle irw pulse.
module instr_fetch #(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        fetch_en,
   input  logic        stall,
   input  logic        redirect,
   input  logic [15:0] redirect_pc,
   output logic        mem_req,
   output logic [15:0] mem_addr,
   input  logic [15:0] mem_rdata,
   input  logic        mem_ready,
   output logic [15:0] instr,
   output logic        irw,
   output logic [15:0] pc,
   output logic [15:0] instr_pc,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      DELIV = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic accept;
   logic start;

   // A response is taken only if no redirect lands on the same edge.
   assign accept = (state == REQ) && mem_ready && !redirect;
   assign start  = fetch_en && !stall;

   // NOTE: sequential state uses non-blocking (<=) so every register samples
   // pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // NOTE: state_nxt gets a default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_nxt = state;
      if (redirect) begin
         state_nxt = IDLE;
      end else begin
         unique case (state)
            IDLE:    state_nxt = start ? REQ : IDLE;
            REQ:     state_nxt = mem_ready ? DELIV : REQ;
            DELIV:   state_nxt = start ? REQ : IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Handshake outputs are decoded from state only, so reset clears them at once.
   always_comb begin
      mem_req = 1'b0;
      irw     = 1'b0;
      busy    = 1'b0;
      unique case (state)
         IDLE:    ;
         REQ: begin
            mem_req = 1'b1;
            busy    = 1'b1;
         end
         DELIV: begin
            irw  = 1'b1;
            busy = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc       <= RESET_PC;
         instr    <= 16'h0000;
         instr_pc <= 16'h0000;
      end else if (redirect) begin
         pc <= redirect_pc;
      end else if (accept) begin
         instr    <= mem_rdata;
         instr_pc <= pc;
         pc       <= pc + 16'd1;
      end
   end

   assign mem_addr = pc;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed vector table, corner sequences
// (async reset, PC wrap) and a random run against a transaction-level model.
module tb_instr_fetch;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        fetch_en, stall, redirect, mem_ready;
   logic [15:0] redirect_pc, mem_rdata;
   logic        mem_req, irw, busy;
   logic [15:0] mem_addr, instr, pc, instr_pc;

   logic        w_rst_n, w_fetch_en, w_mem_ready;
   logic [15:0] w_mem_rdata;
   logic        w_mem_req, w_irw, w_busy;
   logic [15:0] w_mem_addr, w_instr, w_pc, w_instr_pc;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   instr_fetch dut (
      .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .stall(stall),
      .redirect(redirect), .redirect_pc(redirect_pc), .mem_req(mem_req),
      .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .instr(instr), .irw(irw), .pc(pc), .instr_pc(instr_pc), .busy(busy)
   );

   instr_fetch #(.RESET_PC(16'hFFFE)) dut_wrap (
      .clk(clk), .rst_n(w_rst_n), .fetch_en(w_fetch_en), .stall(1'b0),
      .redirect(1'b0), .redirect_pc(16'h0000), .mem_req(w_mem_req),
      .mem_addr(w_mem_addr), .mem_rdata(w_mem_rdata), .mem_ready(w_mem_ready),
      .instr(w_instr), .irw(w_irw), .pc(w_pc), .instr_pc(w_instr_pc), .busy(w_busy)
   );

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic        fe, st, rd;
      logic [15:0] rpc;
      logic        rdy;
      logic [15:0] rdata;
      logic        e_req, e_irw;
      logic [15:0] e_instr, e_ipc, e_pc;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic fe, logic st, logic rd, logic [15:0] rpc, logic rdy,
                               logic [15:0] rdata, logic e_req, logic e_irw,
                               logic [15:0] e_instr, logic [15:0] e_ipc, logic [15:0] e_pc);
      vec_t v;
      v.fe = fe; v.st = st; v.rd = rd; v.rpc = rpc; v.rdy = rdy; v.rdata = rdata;
      v.e_req = e_req; v.e_irw = e_irw; v.e_instr = e_instr; v.e_ipc = e_ipc; v.e_pc = e_pc;
      return v;
   endfunction

   // Transaction-level reference: what is outstanding, what was delivered.
   logic        m_req, m_irw;
   logic [15:0] m_pc, m_instr, m_ipc;

   task automatic model_reset();
      m_req = 0; m_irw = 0; m_pc = 16'h0000; m_instr = 16'h0000; m_ipc = 16'h0000;
   endtask

   task automatic model_edge();
      logic n_req, n_irw;
      n_req = 0; n_irw = 0;
      if (redirect) begin
         m_pc = redirect_pc;
      end else if (m_req) begin
         if (mem_ready) begin
            m_instr = mem_rdata; m_ipc = m_pc; m_pc = m_pc + 16'd1; n_irw = 1;
         end else begin
            n_req = 1;
         end
      end else if (fetch_en && !stall) begin
         n_req = 1;
      end
      m_req = n_req; m_irw = n_irw;
   endtask

   task automatic check_outputs(input string tag, input logic e_req, input logic e_irw,
                                input logic [15:0] e_instr, input logic [15:0] e_ipc,
                                input logic [15:0] e_pc);
      check({tag, ".mem_req"},  {15'd0, mem_req}, {15'd0, e_req});
      check({tag, ".irw"},      {15'd0, irw},     {15'd0, e_irw});
      check({tag, ".busy"},     {15'd0, busy},    {15'd0, e_req | e_irw});
      check({tag, ".pc"},       pc,               e_pc);
      check({tag, ".mem_addr"}, mem_addr,         e_pc);
      check({tag, ".instr"},    instr,            e_instr);
      check({tag, ".instr_pc"}, instr_pc,         e_ipc);
   endtask

   task automatic drive(input logic fe, input logic st, input logic rd, input logic [15:0] rpc,
                        input logic rdy, input logic [15:0] rdata);
      fetch_en = fe; stall = st; redirect = rd; redirect_pc = rpc;
      mem_ready = rdy; mem_rdata = rdata;
   endtask

   initial begin
      rst_n = 0; w_rst_n = 0;
      drive(0, 0, 0, 16'h0, 0, 16'h0);
      w_fetch_en = 0; w_mem_ready = 0; w_mem_rdata = 16'h0;

      // fe st rd rpc rdy rdata | req irw instr ipc pc
      vecs.push_back(mk(1,0,0,16'h0000,0,16'h0000, 1,0,16'h0000,16'h0000,16'h0000));
      vecs.push_back(mk(1,0,0,16'h0000,1,16'hA5A5, 0,1,16'hA5A5,16'h0000,16'h0001));
      vecs.push_back(mk(1,0,0,16'h0000,0,16'h0000, 1,0,16'hA5A5,16'h0000,16'h0001));
      vecs.push_back(mk(1,0,0,16'h0000,1,16'hA5A4, 0,1,16'hA5A4,16'h0001,16'h0002));
      vecs.push_back(mk(1,0,0,16'h0000,0,16'h0000, 1,0,16'hA5A4,16'h0001,16'h0002));
      vecs.push_back(mk(1,0,0,16'h0000,1,16'hA5A7, 0,1,16'hA5A7,16'h0002,16'h0003));
      vecs.push_back(mk(0,0,0,16'h0000,0,16'h0000, 0,0,16'hA5A7,16'h0002,16'h0003));
      vecs.push_back(mk(0,0,1,16'h0010,0,16'h0000, 0,0,16'hA5A7,16'h0002,16'h0010));
      // three wait states at 0x0010
      vecs.push_back(mk(1,0,0,16'h0000,0,16'h0000, 1,0,16'hA5A7,16'h0002,16'h0010));
      vecs.push_back(mk(1,0,0,16'h0000,0,16'h0000, 1,0,16'hA5A7,16'h0002,16'h0010));
      vecs.push_back(mk(1,0,0,16'h0000,0,16'h0000, 1,0,16'hA5A7,16'h0002,16'h0010));
      vecs.push_back(mk(1,0,0,16'h0000,0,16'h0000, 1,0,16'hA5A7,16'h0002,16'h0010));
      vecs.push_back(mk(1,0,0,16'h0000,1,16'h1234, 0,1,16'h1234,16'h0010,16'h0011));
      // redirect wins over a simultaneous ready
      vecs.push_back(mk(1,0,0,16'h0000,0,16'h0000, 1,0,16'h1234,16'h0010,16'h0011));
      vecs.push_back(mk(1,0,1,16'h0200,1,16'hBEEF, 0,0,16'h1234,16'h0010,16'h0200));
      vecs.push_back(mk(1,0,0,16'h0000,0,16'h0000, 1,0,16'h1234,16'h0010,16'h0200));
      vecs.push_back(mk(1,0,0,16'h0000,1,16'h5555, 0,1,16'h5555,16'h0200,16'h0201));
      // stall during REQ for five cycles
      vecs.push_back(mk(1,0,0,16'h0000,0,16'h0000, 1,0,16'h5555,16'h0200,16'h0201));
      vecs.push_back(mk(1,1,0,16'h0000,0,16'h0000, 1,0,16'h5555,16'h0200,16'h0201));
      vecs.push_back(mk(1,1,0,16'h0000,1,16'h7777, 0,1,16'h7777,16'h0201,16'h0202));
      vecs.push_back(mk(1,1,0,16'h0000,0,16'h0000, 0,0,16'h7777,16'h0201,16'h0202));
      vecs.push_back(mk(1,1,0,16'h0000,1,16'h0000, 0,0,16'h7777,16'h0201,16'h0202));
      vecs.push_back(mk(1,1,0,16'h0000,0,16'h0000, 0,0,16'h7777,16'h0201,16'h0202));
      vecs.push_back(mk(1,0,0,16'h0000,0,16'h0000, 1,0,16'h7777,16'h0201,16'h0202));
      vecs.push_back(mk(1,0,0,16'h0000,1,16'h9999, 0,1,16'h9999,16'h0202,16'h0203));
      // redirect in DELIV: pulse already seen, next state IDLE
      vecs.push_back(mk(1,0,1,16'h0300,0,16'h0000, 0,0,16'h9999,16'h0202,16'h0300));

      repeat (2) @(posedge clk);
      #1;
      check_outputs("reset", 0, 0, 16'h0000, 16'h0000, 16'h0000);
      rst_n = 1;
      #2;
      foreach (vecs[i]) begin
         drive(vecs[i].fe, vecs[i].st, vecs[i].rd, vecs[i].rpc, vecs[i].rdy, vecs[i].rdata);
         @(posedge clk);
         #1;
         check_outputs($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_irw,
                       vecs[i].e_instr, vecs[i].e_ipc, vecs[i].e_pc);
      end

      // Async reset mid-REQ at 0x0042
      drive(0, 0, 1, 16'h0042, 0, 16'h0);
      @(posedge clk); #1;
      drive(1, 0, 0, 16'h0, 0, 16'h0);
      @(posedge clk); #1;
      check("rst_pre.mem_req", {15'd0, mem_req}, 16'd1);
      check("rst_pre.mem_addr", mem_addr, 16'h0042);
      #2 rst_n = 0;
      #1;
      check_outputs("rst_async", 0, 0, 16'h0000, 16'h0000, 16'h0000);
      drive(0, 0, 0, 16'h0, 1, 16'hDEAD);
      @(negedge clk);
      rst_n = 1;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         check_outputs($sformatf("rst_post%0d", k), 0, 0, 16'h0000, 16'h0000, 16'h0000);
      end

      // PC wrap from RESET_PC = 0xFFFE, zero-wait memory
      w_fetch_en = 1; w_mem_ready = 1; w_mem_rdata = 16'h4321;
      #1 w_rst_n = 1;
      begin
         logic [15:0] exp_ipc[3];
         int          got;
         exp_ipc[0] = 16'hFFFE; exp_ipc[1] = 16'hFFFF; exp_ipc[2] = 16'h0000;
         got = 0;
         for (int k = 0; k < 8 && got < 3; k++) begin
            @(posedge clk); #1;
            if (w_irw) begin
               check($sformatf("wrap.instr_pc%0d", got), w_instr_pc, exp_ipc[got]);
               got++;
            end
         end
         check("wrap.deliveries", 16'(got), 16'd3);
         check("wrap.pc", w_pc, 16'h0001);
      end
      w_fetch_en = 0;

      // Randomized run against the reference model
      drive(0, 0, 0, 16'h0, 0, 16'h0);
      rst_n = 0;
      #3 rst_n = 1;
      model_reset();
      for (int c = 0; c < 3000; c++) begin
         drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
               $urandom_range(0, 15) == 0, 16'($urandom),
               $urandom_range(0, 2) != 0, 16'($urandom));
         @(posedge clk);
         model_edge();
         #1;
         check_outputs($sformatf("rnd%0d", c), m_req, m_irw, m_instr, m_ipc, m_pc);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
